// File: rtl/xor_pkg.sv
// Shared definitions for the XOR stream scrambler: mode encodings and the
// Galois LFSR step used to generate the keystream.
package xor_pkg;

    localparam logic XOR_MODE_STATIC = 1'b0;
    localparam logic XOR_MODE_LFSR   = 1'b1;

    // Widest LFSR the step function supports; narrower states are zero-extended.
    localparam int XOR_MAX_BITS = 64;

    // Right-shift Galois step: shift out bit 0 and fold the tap mask in when it was set.
    function automatic logic [XOR_MAX_BITS-1:0] xor_lfsr_next(
        input logic [XOR_MAX_BITS-1:0] state,
        input logic [XOR_MAX_BITS-1:0] poly
    );
        return (state >> 1) ^ (state[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/xor_pipe_stage.sv
// One valid/data register of the scrambler pipeline. It loads whenever it is
// empty or its current word is being taken downstream.
module xor_pipe_stage
    import xor_pkg::*;
#(
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 up_valid,
    input  logic [DATA_BITS-1:0] up_data,
    input  logic                 down_ready,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data
);

    logic advance;

    assign advance = !valid | down_ready;

    // Data only reloads on a real word so a stalled or drained stage keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (advance) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/xor_stream_scrambler.sv
// Valid/ready streaming XOR scrambler: each accepted word is XORed with either a
// static key or a Galois LFSR keystream, then carried through PAR_STAGES registers.
module xor_stream_scrambler
    import xor_pkg::*;
#(
    parameter int                       PAR_DATA_BITS = 16,
    parameter logic [PAR_DATA_BITS-1:0] PAR_XOR       = 16'hA5A5,
    parameter logic [PAR_DATA_BITS-1:0] PAR_LFSR_POLY = 16'hB400,
    parameter logic [PAR_DATA_BITS-1:0] PAR_LFSR_SEED = 16'hACE1,
    parameter int                       PAR_STAGES    = 2
) (
    input  logic                     ib_clk,
    input  logic                     ib_rst_n,
    input  logic                     ib_mode,
    input  logic                     ib_reseed,
    input  logic [PAR_DATA_BITS-1:0] ivG_seed,
    input  logic                     ib_in_valid,
    output logic                     ob_in_ready,
    input  logic [PAR_DATA_BITS-1:0] ivG_in_data,
    output logic                     ob_out_valid,
    input  logic                     ib_out_ready,
    output logic [PAR_DATA_BITS-1:0] ovG_out_data,
    output logic [31:0]              ovG_beat_cnt
);

    localparam int W = PAR_DATA_BITS;

    logic [W-1:0]            lfsr;
    logic [W-1:0]            lfsr_step;
    logic [W-1:0]            seed_load;
    logic [W-1:0]            key;
    logic [W-1:0]            word_p0;
    logic [XOR_MAX_BITS-1:0] lfsr_wide;
    logic                    accept;

    logic [PAR_STAGES-1:0]   valid_v;
    logic [PAR_STAGES-1:0]   down_ready;
    logic [W-1:0]            data_p [PAR_STAGES];

    assign accept    = ib_in_valid & ob_in_ready;
    assign key       = (ib_mode == XOR_MODE_LFSR) ? lfsr : PAR_XOR;
    assign word_p0   = ivG_in_data ^ key;
    assign seed_load = (ivG_seed == '0) ? PAR_LFSR_SEED : ivG_seed;

    assign lfsr_wide = xor_lfsr_next(XOR_MAX_BITS'(lfsr), XOR_MAX_BITS'(PAR_LFSR_POLY));
    assign lfsr_step = lfsr_wide[W-1:0];

    if (W < XOR_MAX_BITS) begin : g_wide_hi
        logic unused_hi;
        assign unused_hi = ^lfsr_wide[XOR_MAX_BITS-1:W];
    end

    // A reseed load overrides the step; the beat in that cycle already used the old state.
    always_ff @(posedge ib_clk or negedge ib_rst_n) begin
        if (!ib_rst_n) begin
            lfsr <= PAR_LFSR_SEED;
        end else if (ib_reseed) begin
            lfsr <= seed_load;
        end else if (accept && ib_mode == XOR_MODE_LFSR) begin
            lfsr <= lfsr_step;
        end
    end

    always_ff @(posedge ib_clk or negedge ib_rst_n) begin
        if (!ib_rst_n) begin
            ovG_beat_cnt <= '0;
        end else if (accept) begin
            ovG_beat_cnt <= ovG_beat_cnt + 32'd1;
        end
    end

    // Stage k may take a new word if the sink is ready or any later stage has a hole,
    // so the ready chain is built from register state and never loops on itself.
    always_comb begin
        logic take;
        take       = ib_out_ready;
        down_ready = '0;
        for (int k = PAR_STAGES - 1; k >= 0; k--) begin
            down_ready[k] = take;
            take          = take | ~valid_v[k];
        end
        ob_in_ready = take;
    end

    for (genvar k = 0; k < PAR_STAGES; k++) begin : g_stage
        logic         up_valid;
        logic [W-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = ib_in_valid;
            assign up_data  = word_p0;
        end else begin : g_body
            assign up_valid = valid_v[k-1];
            assign up_data  = data_p[k-1];
        end

        xor_pipe_stage #(
            .DATA_BITS (W)
        ) u_stage (
            .clk        (ib_clk),
            .rst_n      (ib_rst_n),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (down_ready[k]),
            .valid      (valid_v[k]),
            .data       (data_p[k])
        );
    end

    assign ob_out_valid = valid_v[PAR_STAGES-1];
    assign ovG_out_data = data_p[PAR_STAGES-1];

endmodule

// File: tb/tb_xor_stream_scrambler.sv
// Self-checking bench for xor_stream_scrambler: scenario tasks against a queue-based
// reference model, plus an encoder/decoder pair for the round-trip property.
module tb_xor_stream_scrambler;

    localparam int RT_N = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0, reseed = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] seed = '0, in_data = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [31:0] beat_cnt;

    logic        e_mode = 1'b0, e_in_valid = 1'b0;
    logic [15:0] e_in_data = '0;
    logic        e_in_ready, e_out_valid;
    logic [15:0] e_out_data;
    logic [31:0] e_cnt;
    logic        d_mode = 1'b0, d_out_ready = 1'b0;
    logic        d_in_ready, d_out_valid;
    logic [15:0] d_out_data;
    logic [31:0] d_cnt;
    logic        zero_bit = 1'b0;
    logic [15:0] zero_word = '0;

    always #5 clk = ~clk;

    xor_stream_scrambler u_dut (
        .ib_clk(clk), .ib_rst_n(rst_n), .ib_mode(mode), .ib_reseed(reseed), .ivG_seed(seed),
        .ib_in_valid(in_valid), .ob_in_ready(in_ready), .ivG_in_data(in_data),
        .ob_out_valid(out_valid), .ib_out_ready(out_ready), .ovG_out_data(out_data),
        .ovG_beat_cnt(beat_cnt)
    );

    xor_stream_scrambler u_enc (
        .ib_clk(clk), .ib_rst_n(rst_n), .ib_mode(e_mode), .ib_reseed(zero_bit), .ivG_seed(zero_word),
        .ib_in_valid(e_in_valid), .ob_in_ready(e_in_ready), .ivG_in_data(e_in_data),
        .ob_out_valid(e_out_valid), .ib_out_ready(d_in_ready), .ovG_out_data(e_out_data),
        .ovG_beat_cnt(e_cnt)
    );

    xor_stream_scrambler u_dec (
        .ib_clk(clk), .ib_rst_n(rst_n), .ib_mode(d_mode), .ib_reseed(zero_bit), .ivG_seed(zero_word),
        .ib_in_valid(e_out_valid), .ob_in_ready(d_in_ready), .ivG_in_data(e_out_data),
        .ob_out_valid(d_out_valid), .ib_out_ready(d_out_ready), .ovG_out_data(d_out_data),
        .ovG_beat_cnt(d_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_lfsr;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          cyc = 0;

    // Results of the most recent cycle() call
    logic        c_acc, c_emit, c_ready, c_valid;
    logic [15:0] c_data;
    int          c_occ, c_idx;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] taps;
        taps = (s % 2 == 1) ? 16'hB400 : 16'h0000;
        return (s / 2) ^ taps;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; reseed = 1'b0; out_ready = 1'b0;
        e_in_valid = 1'b0; d_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
        exp_q.delete();
        got_q.delete();
    endtask

    // Drives one clock of the main DUT, samples mid-cycle and advances the model.
    task automatic cycle(input logic v, input logic [15:0] d, input logic m,
                         input logic rs, input logic [15:0] sd, input logic ordy);
        logic [15:0] k;
        @(negedge clk);
        in_valid = v; in_data = d; mode = m; reseed = rs; seed = sd; out_ready = ordy;
        #1;
        c_idx   = cyc;
        c_occ   = exp_q.size() - got_q.size();
        c_ready = in_ready;
        c_valid = out_valid;
        c_data  = out_data;
        c_acc   = v & in_ready;
        c_emit  = out_valid & ordy;
        if (c_emit) got_q.push_back(out_data);
        if (c_acc) begin
            k = m ? m_lfsr : 16'hA5A5;
            exp_q.push_back(d ^ k);
            if (m) m_lfsr = model_step(m_lfsr);
        end
        if (rs) m_lfsr = (sd != 16'h0000) ? sd : 16'hACE1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        n_vec++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_data got=%h want=0000", out_data); end
        n_vec++; if (beat_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", beat_cnt); end
        do_reset();
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_static();
        int acc_idx, emit_idx;
        logic [15:0] g;
        do_reset();
        acc_idx = -1; emit_idx = -1;
        cycle(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1);
        if (c_acc) acc_idx = c_idx;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (c_emit && emit_idx < 0) emit_idx = c_idx;
        end
        n_vec++;
        if (acc_idx < 0 || emit_idx - acc_idx != 2) begin
            n_err++; $display("FAIL static_latency got=%0d want=2", emit_idx - acc_idx);
        end
        g = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
        n_vec++; if (got_q.size() != 1 || g !== 16'hB791) begin
            n_err++; $display("FAIL static_data got=%h (n=%0d) want=b791", g, got_q.size());
        end
        n_vec++; if (beat_cnt !== 32'd1) begin n_err++; $display("FAIL static_cnt got=%0d want=1", beat_cnt); end
    endtask

    task automatic test_lfsr();
        logic [15:0] lit1[3] = '{16'hACE1, 16'hE270, 16'h7138};
        logic [15:0] lit2[5] = '{16'hACE1, 16'hA5A5, 16'hE270, 16'hA5A5, 16'h7138};
        logic        m2[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        idle(4);
        n_vec++; if (got_q.size() != 3) begin n_err++; $display("FAIL lfsr_count got=%0d want=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== lit1[i]) begin
                n_err++; $display("FAIL lfsr_key[%0d] got=%h want=%h", i, got_q[i], lit1[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0000, m2[i], 1'b0, 16'h0000, 1'b1);
        idle(4);
        n_vec++; if (got_q.size() != 5) begin n_err++; $display("FAIL mixed_count got=%0d want=5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== lit2[i]) begin
                n_err++; $display("FAIL mixed_key[%0d] got=%h want=%h", i, got_q[i], lit2[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] w[8];
        logic        md[8];
        int          sent;
        logic        ordy, prev_stall, exp_ready;
        logic [15:0] prev_data;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w[i]  = 16'($urandom);
            md[i] = (i % 2 == 0) ? 1'b1 : 1'($urandom);
        end
        sent = 0; prev_stall = 1'b0; prev_data = '0;
        for (int t = 0; t < 100 && got_q.size() < 8; t++) begin
            ordy = (t % 3 == 0);
            cycle(sent < 8, (sent < 8) ? w[sent] : 16'h0000, (sent < 8) ? md[sent] : 1'b0,
                  1'b0, 16'h0000, ordy);
            exp_ready = (c_occ < 2) | ordy;
            n_vec++; if (c_ready !== exp_ready) begin
                n_err++; $display("FAIL bp_in_ready t=%0d occ=%0d got=%b want=%b", t, c_occ, c_ready, exp_ready);
            end
            if (prev_stall) begin
                n_vec++; if (c_valid !== 1'b1 || c_data !== prev_data) begin
                    n_err++; $display("FAIL bp_stall_hold t=%0d got=%b/%h want=1/%h", t, c_valid, c_data, prev_data);
                end
            end
            prev_stall = c_valid & !ordy;
            prev_data  = c_data;
            if (c_acc) sent++;
        end
        n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL bp_count got=%0d want=8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reseed();
        logic [15:0] lit[5] = '{16'hACE1, 16'hE270, 16'hACE1, 16'h0001, 16'hB400};
        do_reset();
        cycle(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1);
        cycle(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1);
        cycle(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        idle(4);
        n_vec++; if (got_q.size() != 5) begin n_err++; $display("FAIL reseed_count got=%0d want=5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== lit[i] || got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL reseed_key[%0d] got=%h want=%h", i, got_q[i], lit[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] g;
        do_reset();
        cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b1 || beat_cnt !== 32'd2) begin
            n_err++; $display("FAIL mid_inflight got=%b/%0d want=1/2", out_valid, beat_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_drop got=%b want=0", out_valid); end
        n_vec++; if (beat_cnt !== 32'd0) begin n_err++; $display("FAIL mid_cnt got=%0d want=0", beat_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = 16'hACE1; exp_q.delete(); got_q.delete();
        cycle(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        idle(4);
        g = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
        n_vec++; if (got_q.size() != 1 || g !== 16'hACE1) begin
            n_err++; $display("FAIL mid_first_key got=%h (n=%0d) want=ace1", g, got_q.size());
        end
    endtask

    task automatic test_round_trip();
        logic [15:0] words[RT_N];
        logic        modes[RT_N];
        int          sent, d_idx, recv;
        do_reset();
        for (int i = 0; i < RT_N; i++) begin
            words[i] = 16'($urandom);
            modes[i] = 1'($urandom);
        end
        sent = 0; d_idx = 0; recv = 0;
        for (int t = 0; t < 20000 && recv < RT_N; t++) begin
            @(negedge clk);
            e_in_valid  = (sent < RT_N) && ($urandom_range(3) != 0);
            e_in_data   = (sent < RT_N) ? words[sent] : 16'h0000;
            e_mode      = (sent < RT_N) ? modes[sent] : 1'b0;
            d_mode      = (d_idx < RT_N) ? modes[d_idx] : 1'b0;
            d_out_ready = ($urandom_range(3) != 0);
            #1;
            if (e_in_valid && e_in_ready) sent++;
            if (e_out_valid && d_in_ready) d_idx++;
            if (d_out_valid && d_out_ready) begin
                n_vec++;
                if (recv >= RT_N || d_out_data !== words[recv]) begin
                    n_err++; $display("FAIL rt_word[%0d] got=%h want=%h", recv, d_out_data,
                                      (recv < RT_N) ? words[recv] : 16'hxxxx);
                end
                recv++;
            end
        end
        @(negedge clk);
        e_in_valid = 1'b0; d_out_ready = 1'b0;
        #1;
        n_vec++; if (recv != RT_N) begin n_err++; $display("FAIL rt_count got=%0d want=%0d", recv, RT_N); end
        n_vec++; if (e_cnt !== 32'(RT_N) || d_cnt !== 32'(RT_N)) begin
            n_err++; $display("FAIL rt_beat_cnt got=%0d/%0d want=%0d", e_cnt, d_cnt, RT_N);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_lfsr();
        test_backpressure();
        test_reseed();
        test_reset_midstream();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
